multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I datapath.
- Decodes the instruction register contents and sequences every datapath control input (PC/IR enables, address, ALU-source and result muxes, immediate select, ALU op, register-file write, memory write) cycle by cycle.
- Supports R-type ALU, I-type ALU, lw, sw, beq/bne, jal and jalr; any other encoding is flagged illegal.

---
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath: decodes the IR and
// drives every datapath enable and mux select one state at a time.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        we_pc,
    output logic        we_ir,
    output logic        sel_mem_addr,
    output logic [1:0]  sel_alu_src_a,
    output logic [1:0]  sel_alu_src_b,
    output logic [1:0]  sel_result,
    output logic [2:0]  sel_ext,
    output logic [3:0]  alu_control,
    output logic        we_rf,
    output logic        we_mem,
    output logic        illegal_instr
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADR    = 4'd2,
        MEMREAD   = 4'd3,
        MEMWB     = 4'd4,
        MEMWRITE  = 4'd5,
        EXECR     = 4'd6,
        EXECI     = 4'd7,
        ALUWB     = 4'd8,
        BRANCH    = 4'd9,
        JAL       = 4'd10,
        JALR      = 4'd11,
        JALR_LINK = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_S = 3'b001;
    localparam logic [2:0] EXT_B = 3'b010;
    localparam logic [2:0] EXT_J = 3'b011;

    state_t state, next_state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign bit30  = instr[30];

    // instr[30] selects SUB only for register ops; it always picks SRA for shifts
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       b30,
                                              input logic       is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state    = FETCH;
        we_pc         = 1'b0;
        we_ir         = 1'b0;
        sel_mem_addr  = 1'b0;
        sel_alu_src_a = 2'd0;
        sel_alu_src_b = 2'd0;
        sel_result    = 2'd0;
        sel_ext       = EXT_I;
        alu_control   = ALU_ADD;
        we_rf         = 1'b0;
        we_mem        = 1'b0;
        illegal_instr = 1'b0;

        // Reset holds every output at its quiet value regardless of state
        if (!rst) begin
            case (state)
                FETCH: begin
                    we_ir         = 1'b1;
                    sel_alu_src_b = 2'd2;
                    sel_result    = 2'd2;
                    we_pc         = 1'b1;
                    next_state    = DECODE;
                end
                DECODE: begin
                    sel_alu_src_a = 2'd1;
                    sel_alu_src_b = 2'd1;
                    sel_ext       = (opcode == OP_JAL) ? EXT_J : EXT_B;
                    if (opcode == OP_LOAD || opcode == OP_STORE)            next_state = MEMADR;
                    else if (opcode == OP_RTYPE)                            next_state = EXECR;
                    else if (opcode == OP_ITYPE)                            next_state = EXECI;
                    else if (opcode == OP_BRANCH && funct3[2:1] == 2'b00)  next_state = BRANCH;
                    else if (opcode == OP_JAL)                              next_state = JAL;
                    else if (opcode == OP_JALR && funct3 == 3'b000)        next_state = JALR;
                    else                                                    illegal_instr = 1'b1;
                end
                MEMADR: begin
                    sel_alu_src_a = 2'd2;
                    sel_alu_src_b = 2'd1;
                    sel_ext       = (opcode == OP_STORE) ? EXT_S : EXT_I;
                    next_state    = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    sel_mem_addr = 1'b1;
                    next_state   = MEMWB;
                end
                MEMWB: begin
                    sel_result = 2'd1;
                    we_rf      = 1'b1;
                end
                MEMWRITE: begin
                    sel_mem_addr = 1'b1;
                    we_mem       = 1'b1;
                end
                EXECR: begin
                    sel_alu_src_a = 2'd2;
                    alu_control   = alu_decode(funct3, bit30, 1'b1);
                    next_state    = ALUWB;
                end
                EXECI: begin
                    sel_alu_src_a = 2'd2;
                    sel_alu_src_b = 2'd1;
                    alu_control   = alu_decode(funct3, bit30, 1'b0);
                    next_state    = ALUWB;
                end
                ALUWB: begin
                    we_rf = 1'b1;
                end
                BRANCH: begin
                    sel_alu_src_a = 2'd2;
                    alu_control   = ALU_SUB;
                    we_pc         = funct3[0] ? ~zero : zero;
                end
                JAL: begin
                    sel_alu_src_a = 2'd1;
                    sel_alu_src_b = 2'd2;
                    we_pc         = 1'b1;
                    next_state    = ALUWB;
                end
                // Target bit 0 is passed through untouched
                JALR: begin
                    sel_alu_src_a = 2'd2;
                    sel_alu_src_b = 2'd1;
                    sel_result    = 2'd2;
                    we_pc         = 1'b1;
                    next_state    = JALR_LINK;
                end
                JALR_LINK: begin
                    sel_alu_src_a = 2'd1;
                    sel_alu_src_b = 2'd2;
                    next_state    = ALUWB;
                end
                default: next_state = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the whole packed control word per state.
module tb_multicycle_controller;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        we_pc, we_ir, sel_mem_addr, we_rf, we_mem, illegal_instr;
    logic [1:0]  sel_alu_src_a, sel_alu_src_b, sel_result;
    logic [2:0]  sel_ext;
    logic [3:0]  alu_control;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .zero          (zero),
        .we_pc         (we_pc),
        .we_ir         (we_ir),
        .sel_mem_addr  (sel_mem_addr),
        .sel_alu_src_a (sel_alu_src_a),
        .sel_alu_src_b (sel_alu_src_b),
        .sel_result    (sel_result),
        .sel_ext       (sel_ext),
        .alu_control   (alu_control),
        .we_rf         (we_rf),
        .we_mem        (we_mem),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed order: we_pc we_ir mem_addr src_a src_b result ext alu we_rf we_mem illegal
    function automatic logic [18:0] ctl(input logic pc, input logic ir, input logic ma,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] res, input logic [2:0] ext,
                                        input logic [3:0] alu, input logic rf,
                                        input logic mem, input logic ill);
        return {pc, ir, ma, sa, sb, res, ext, alu, rf, mem, ill};
    endfunction

    function automatic logic [18:0] observed();
        return {we_pc, we_ir, sel_mem_addr, sel_alu_src_a, sel_alu_src_b, sel_result,
                sel_ext, alu_control, we_rf, we_mem, illegal_instr};
    endfunction

    task automatic applyStimulus(input logic [31:0] new_instr, input logic new_zero);
        instr = new_instr;
        zero  = new_zero;
    endtask

    task automatic checkOutput(input string tag, input logic [18:0] expected);
        logic [18:0] obs;
        obs = observed();
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expected);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [18:0] quiet, fetch_v, dec_b, dec_j, aluwb_v;

    initial begin
        quiet   = '0;
        fetch_v = ctl(1, 1, 0, 2'd0, 2'd2, 2'd2, 3'b000, 4'b0000, 0, 0, 0);
        dec_b   = ctl(0, 0, 0, 2'd1, 2'd1, 2'd0, 3'b010, 4'b0000, 0, 0, 0);
        dec_j   = ctl(0, 0, 0, 2'd1, 2'd1, 2'd0, 3'b011, 4'b0000, 0, 0, 0);
        aluwb_v = ctl(0, 0, 0, 2'd0, 2'd0, 2'd0, 3'b000, 4'b0000, 1, 0, 0);

        rst = 1'b1;
        applyStimulus(32'h0080A283, 1'b0);
        step_cycle();
        step_cycle();
        checkOutput("reset_quiet", quiet);
        rst = 1'b0;
        #1;
        checkOutput("lw_fetch", fetch_v);

        // lw x5,8(x1): 5 cycles
        step_cycle(); checkOutput("lw_decode", dec_b);
        step_cycle(); checkOutput("lw_memadr", ctl(0, 0, 0, 2'd2, 2'd1, 2'd0, 3'b000, 4'b0000, 0, 0, 0));
        step_cycle(); checkOutput("lw_memread", ctl(0, 0, 1, 2'd0, 2'd0, 2'd0, 3'b000, 4'b0000, 0, 0, 0));
        step_cycle(); checkOutput("lw_memwb", ctl(0, 0, 0, 2'd0, 2'd0, 2'd1, 3'b000, 4'b0000, 1, 0, 0));
        step_cycle(); checkOutput("sw_fetch", fetch_v);

        // sw x5,8(x1): 4 cycles
        applyStimulus(32'h0050A423, 1'b0);
        step_cycle(); checkOutput("sw_decode", dec_b);
        step_cycle(); checkOutput("sw_memadr", ctl(0, 0, 0, 2'd2, 2'd1, 2'd0, 3'b001, 4'b0000, 0, 0, 0));
        step_cycle(); checkOutput("sw_memwrite", ctl(0, 0, 1, 2'd0, 2'd0, 2'd0, 3'b000, 4'b0000, 0, 1, 0));
        step_cycle(); checkOutput("add_fetch", fetch_v);

        // add x3,x1,x2
        applyStimulus(32'h002081B3, 1'b0);
        step_cycle(); checkOutput("add_decode", dec_b);
        step_cycle(); checkOutput("add_execr", ctl(0, 0, 0, 2'd2, 2'd0, 2'd0, 3'b000, 4'b0000, 0, 0, 0));
        step_cycle(); checkOutput("add_aluwb", aluwb_v);
        step_cycle(); checkOutput("sub_fetch", fetch_v);

        // sub x3,x1,x2
        applyStimulus(32'h402081B3, 1'b0);
        step_cycle(); checkOutput("sub_decode", dec_b);
        step_cycle(); checkOutput("sub_execr", ctl(0, 0, 0, 2'd2, 2'd0, 2'd0, 3'b000, 4'b0001, 0, 0, 0));
        step_cycle(); checkOutput("sub_aluwb", aluwb_v);
        step_cycle(); checkOutput("addi_fetch", fetch_v);

        // addi x1,x1,0x401: bit 30 set must still give ADD
        applyStimulus(32'h40108093, 1'b0);
        step_cycle(); checkOutput("addi_decode", dec_b);
        step_cycle(); checkOutput("addi_execi", ctl(0, 0, 0, 2'd2, 2'd1, 2'd0, 3'b000, 4'b0000, 0, 0, 0));
        step_cycle(); checkOutput("addi_aluwb", aluwb_v);
        step_cycle(); checkOutput("srai_fetch", fetch_v);

        // srai x1,x1,1: bit 30 selects SRA
        applyStimulus(32'h4010D093, 1'b0);
        step_cycle(); checkOutput("srai_decode", dec_b);
        step_cycle(); checkOutput("srai_execi", ctl(0, 0, 0, 2'd2, 2'd1, 2'd0, 3'b000, 4'b1001, 0, 0, 0));
        step_cycle(); checkOutput("srai_aluwb", aluwb_v);
        step_cycle(); checkOutput("beq_t_fetch", fetch_v);

        // beq taken / not taken, bne with zero=1
        applyStimulus(32'h00208463, 1'b1);
        step_cycle(); checkOutput("beq_t_decode", dec_b);
        step_cycle(); checkOutput("beq_t_branch", ctl(1, 0, 0, 2'd2, 2'd0, 2'd0, 3'b000, 4'b0001, 0, 0, 0));
        step_cycle(); checkOutput("beq_n_fetch", fetch_v);
        applyStimulus(32'h00208463, 1'b0);
        step_cycle(); checkOutput("beq_n_decode", dec_b);
        step_cycle(); checkOutput("beq_n_branch", ctl(0, 0, 0, 2'd2, 2'd0, 2'd0, 3'b000, 4'b0001, 0, 0, 0));
        step_cycle(); checkOutput("bne_fetch", fetch_v);
        applyStimulus(32'h00209463, 1'b1);
        step_cycle(); checkOutput("bne_decode", dec_b);
        step_cycle(); checkOutput("bne_branch", ctl(0, 0, 0, 2'd2, 2'd0, 2'd0, 3'b000, 4'b0001, 0, 0, 0));
        step_cycle(); checkOutput("jal_fetch", fetch_v);

        // jal x1,8
        applyStimulus(32'h008000EF, 1'b0);
        step_cycle(); checkOutput("jal_decode", dec_j);
        step_cycle(); checkOutput("jal_jal", ctl(1, 0, 0, 2'd1, 2'd2, 2'd0, 3'b000, 4'b0000, 0, 0, 0));
        step_cycle(); checkOutput("jal_aluwb", aluwb_v);
        step_cycle(); checkOutput("jalr_fetch", fetch_v);

        // jalr x1,0(x1)
        applyStimulus(32'h000080E7, 1'b0);
        step_cycle(); checkOutput("jalr_decode", dec_b);
        step_cycle(); checkOutput("jalr_jalr", ctl(1, 0, 0, 2'd2, 2'd1, 2'd2, 3'b000, 4'b0000, 0, 0, 0));
        step_cycle(); checkOutput("jalr_link", ctl(0, 0, 0, 2'd1, 2'd2, 2'd0, 3'b000, 4'b0000, 0, 0, 0));
        step_cycle(); checkOutput("jalr_aluwb", aluwb_v);
        step_cycle(); checkOutput("ill_fetch", fetch_v);

        // all-zero word is illegal: one DECODE pulse, then FETCH
        applyStimulus(32'h00000000, 1'b0);
        step_cycle(); checkOutput("ill_decode", ctl(0, 0, 0, 2'd1, 2'd1, 2'd0, 3'b010, 4'b0000, 0, 0, 1));
        step_cycle(); checkOutput("rst_lw_fetch", fetch_v);

        // reset during MEMREAD of lw aborts before MEMWB
        applyStimulus(32'h0080A283, 1'b0);
        step_cycle(); checkOutput("rst_lw_decode", dec_b);
        step_cycle(); checkOutput("rst_lw_memadr", ctl(0, 0, 0, 2'd2, 2'd1, 2'd0, 3'b000, 4'b0000, 0, 0, 0));
        step_cycle(); checkOutput("rst_lw_memread", ctl(0, 0, 1, 2'd0, 2'd0, 2'd0, 3'b000, 4'b0000, 0, 0, 0));
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_quiet", quiet);
        step_cycle(); checkOutput("rst_held_quiet", quiet);
        rst = 1'b0;
        #1;
        checkOutput("rst_after_fetch", fetch_v);
        step_cycle(); checkOutput("rst_after_decode", dec_b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
